// File: rtl/frame_xform_pkg.sv
// Shared constants and types for frame_inverse_transform.
// ROUND_NEAREST_EN selects round-half-up quotients (25-bit datapath, 52-edge latency).
package frame_xform_pkg;

`ifdef ROUND_NEAREST_EN
    localparam int unsigned QW = 25;
`else
    localparam int unsigned QW = 24;
`endif

    localparam int unsigned LATENCY = 2 * QW + 2;
    localparam int unsigned CVW     = 13;
    localparam int unsigned TW      = 11;
    localparam int unsigned XW      = 11;
    localparam int unsigned YW      = 10;
    localparam int unsigned SW      = 26;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIVX,
        DIVY,
        FIX
    } state_t;

    // Integer frame center (floor).
    function automatic int unsigned center_of(input int unsigned dim);
        return dim / 2;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per clock, MSB first; the load edge performs
// the first iteration so a DW-bit quotient is ready DW edges after load.
module serial_divider #(
    parameter int unsigned DW = 24,
    parameter int unsigned VW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          active,
    output logic          last_c,
    output logic [DW-1:0] quotient
);
    localparam int unsigned RW = VW + 1;
    localparam int unsigned CW = $clog2(DW + 1);

    logic [VW-1:0] rem, rem_d, rem_in;
    logic [DW-1:0] sh, sh_d, sh_in;
    logic [CW-1:0] cnt, cnt_d;
    logic          active_d;
    logic [RW-1:0] trial;

    assign quotient = sh;

    // Dividend shifts out of the MSB while quotient bits shift into the LSB.
    always_comb begin
        rem_d    = rem;
        sh_d     = sh;
        cnt_d    = cnt;
        active_d = active;
        last_c   = active && (cnt == CW'(DW - 1));
        rem_in   = load ? '0 : rem;
        sh_in    = load ? dividend : sh;
        trial    = {rem_in, sh_in[DW-1]};
        if (load || active) begin
            if (trial >= RW'(divisor)) begin
                rem_d = VW'(trial - RW'(divisor));
                sh_d  = {sh_in[DW-2:0], 1'b1};
            end else begin
                rem_d = VW'(trial);
                sh_d  = {sh_in[DW-2:0], 1'b0};
            end
            cnt_d    = load ? CW'(1) : cnt + CW'(1);
            active_d = load ? 1'b1 : !last_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem    <= '0;
            sh     <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            rem    <= rem_d;
            sh     <= sh_d;
            cnt    <= cnt_d;
            active <= active_d;
        end
    end

endmodule

// File: rtl/frame_inverse_transform.sv
// Maps centered, scaled coordinates back to clamped absolute pixel coordinates.
// Optional ROUND_NEAREST_EN: round-half-up quotients instead of truncation.
module frame_inverse_transform
    import frame_xform_pkg::*;
#(
    parameter int unsigned WIDTH  = 525,
    parameter int unsigned HEIGHT = 525
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [CVW-1:0]  cv_x,
    input  logic            x_neg,
    input  logic [CVW-1:0]  cv_y,
    input  logic            y_neg,
    input  logic [TW-1:0]   t_width,
    input  logic [TW-1:0]   t_height,
    output logic            busy,
    output logic            done,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic            clip
);
    localparam int unsigned CX   = center_of(WIDTH);
    localparam int unsigned CY   = center_of(HEIGHT);
    localparam int unsigned DMAX = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
    localparam int unsigned VW   = $clog2(DMAX + 1);

    state_t          state, state_d;
    logic [CVW-1:0]  cvx, cvx_d, cvy, cvy_d;
    logic            negx, negx_d, negy, negy_d;
    logic [TW-1:0]   tw, tw_d, th, th_d;
    logic [QW-1:0]   prod_x, prod_x_d, prod_y, prod_y_d, qx, qx_d;
    logic            busy_d, done_d, clip_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic signed [SW-1:0] sx, sy;

    logic            div_load_c, div_active, div_last_c;
    logic [QW-1:0]   div_dividend_c, div_quotient;
    logic [VW-1:0]   div_divisor_c;

    serial_divider #(.DW(QW), .VW(VW)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (div_load_c),
        .dividend (div_dividend_c),
        .divisor  (div_divisor_c),
        .active   (div_active),
        .last_c   (div_last_c),
        .quotient (div_quotient)
    );

    // Next-state and datapath; FIX spans the compute cycle and the done cycle.
    always_comb begin
        state_d        = state;
        cvx_d          = cvx;
        cvy_d          = cvy;
        negx_d         = negx;
        negy_d         = negy;
        tw_d           = tw;
        th_d           = th;
        prod_x_d       = prod_x;
        prod_y_d       = prod_y;
        qx_d           = qx;
        busy_d         = busy;
        done_d         = 1'b0;
        x_d            = x;
        y_d            = y;
        clip_d         = clip;
        div_load_c     = 1'b0;
        div_dividend_c = prod_x;
        div_divisor_c  = VW'(WIDTH);
        sx = negx ? SW'(CX) - SW'(qx) : SW'(CX) + SW'(qx);
        sy = negy ? SW'(CY) - SW'(div_quotient) : SW'(CY) + SW'(div_quotient);

        unique case (state)
            IDLE: begin
                if (start) begin
                    cvx_d   = cv_x;
                    negx_d  = x_neg;
                    cvy_d   = cv_y;
                    negy_d  = y_neg;
                    tw_d    = t_width;
                    th_d    = t_height;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
`ifdef ROUND_NEAREST_EN
                prod_x_d = QW'(cvx) * QW'(tw) + QW'(CX);
                prod_y_d = QW'(cvy) * QW'(th) + QW'(CY);
`else
                prod_x_d = QW'(cvx) * QW'(tw);
                prod_y_d = QW'(cvy) * QW'(th);
`endif
                state_d = DIVX;
            end
            DIVX: begin
                div_load_c = !div_active;
                if (div_last_c) state_d = DIVY;
            end
            DIVY: begin
                div_dividend_c = prod_y;
                div_divisor_c  = VW'(HEIGHT);
                if (!div_active) begin
                    div_load_c = 1'b1;
                    qx_d       = div_quotient;
                end
                if (div_last_c) state_d = FIX;
            end
            FIX: begin
                if (!done) begin
                    clip_d = 1'b0;
                    if (sx[SW-1]) begin
                        x_d = '0;
                        clip_d = 1'b1;
                    end else if (sx > $signed(SW'(WIDTH - 1))) begin
                        x_d = XW'(WIDTH - 1);
                        clip_d = 1'b1;
                    end else begin
                        x_d = XW'(sx);
                    end
                    if (sy[SW-1]) begin
                        y_d = '0;
                        clip_d = 1'b1;
                    end else if (sy > $signed(SW'(HEIGHT - 1))) begin
                        y_d = YW'(HEIGHT - 1);
                        clip_d = 1'b1;
                    end else begin
                        y_d = YW'(sy);
                    end
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cvx    <= '0;
            cvy    <= '0;
            negx   <= 1'b0;
            negy   <= 1'b0;
            tw     <= '0;
            th     <= '0;
            prod_x <= '0;
            prod_y <= '0;
            qx     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x      <= '0;
            y      <= '0;
            clip   <= 1'b0;
        end else begin
            state  <= state_d;
            cvx    <= cvx_d;
            cvy    <= cvy_d;
            negx   <= negx_d;
            negy   <= negy_d;
            tw     <= tw_d;
            th     <= th_d;
            prod_x <= prod_x_d;
            prod_y <= prod_y_d;
            qx     <= qx_d;
            busy   <= busy_d;
            done   <= done_d;
            x      <= x_d;
            y      <= y_d;
            clip   <= clip_d;
        end
    end

endmodule

// File: tb/tb_frame_inverse_transform.sv
// Directed bench for frame_inverse_transform (default 525x525 frame).
module tb_frame_inverse_transform;
    import frame_xform_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] cv_x = '0;
    logic        x_neg = 1'b0;
    logic [12:0] cv_y = '0;
    logic        y_neg = 1'b0;
    logic [10:0] t_width = '0;
    logic [10:0] t_height = '0;
    logic        busy, done, clip;
    logic [10:0] x;
    logic [9:0]  y;

    int vectors = 0;
    int miscompares = 0;

`ifdef ROUND_NEAREST_EN
    localparam logic [9:0] Y_SMALL = 10'd263;
`else
    localparam logic [9:0] Y_SMALL = 10'd262;
`endif

    frame_inverse_transform #(.WIDTH(525), .HEIGHT(525)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .cv_x     (cv_x),
        .x_neg    (x_neg),
        .cv_y     (cv_y),
        .y_neg    (y_neg),
        .t_width  (t_width),
        .t_height (t_height),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .clip     (clip)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, x, y, clip} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected 000000", {busy, done, x, y, clip});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One transaction: inputs are scrambled after accept, optional start retrigger at edge 10.
    task automatic run_vector(input string name, input logic [12:0] cvx, input logic xn,
                              input logic [12:0] cvy, input logic yn,
                              input logic [10:0] tw, input logic [10:0] th,
                              input logic [10:0] ex, input logic [9:0] ey, input logic ec,
                              input bit retrig);
        int lat;
        int bc;
        int extra;
        lat = 0;
        bc = 0;
        extra = 0;
        @(negedge clk);
        cv_x = cvx; x_neg = xn; cv_y = cvy; y_neg = yn; t_width = tw; t_height = th;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cv_x = 13'h1abc; x_neg = ~xn; cv_y = 13'h0f0f; y_neg = ~yn; t_width = 11'h7ff; t_height = 11'h3c3;
        if (busy) bc++;
        for (int i = 1; i <= int'(LATENCY) + 5 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
            if (done) lat = i;
            if (retrig && i == 9) begin
                start = 1'b1;
                cv_x = 13'd4000;
            end
            if (i == 10) start = 1'b0;
        end
        vectors++;
        if (lat != int'(LATENCY)) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, LATENCY);
        end
        vectors++;
        if (x !== ex || y !== ey || clip !== ec) begin
            miscompares++;
            $display("FAIL %s result: got x=%0d y=%0d clip=%0b expected x=%0d y=%0d clip=%0b",
                     name, x, y, clip, ex, ey, ec);
        end
        vectors++;
        if (bc != int'(LATENCY) + 1) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, LATENCY + 1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || x !== ex || y !== ey || clip !== ec) begin
            miscompares++;
            $display("FAIL %s after_done: got busy=%0b done=%0b x=%0d y=%0d clip=%0b", name, busy, done, x, y, clip);
        end
        if (retrig) begin
            repeat (60) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            vectors++;
            if (extra != 0) begin
                miscompares++;
                $display("FAIL %s extra_done: got %0d expected 0", name, extra);
            end
        end
    endtask

    task automatic test_abort();
        int dn;
        dn = 0;
        @(negedge clk);
        cv_x = 13'd100; x_neg = 1'b0; cv_y = 13'd50; y_neg = 1'b1; t_width = 11'd525; t_height = 11'd525;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, x, y, clip} !== 24'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h expected 000000", {busy, done, x, y, clip});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        vectors++;
        if (dn != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got done_count=%0d busy=%0b expected 0 0", dn, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = 0;
        @(negedge clk);
        cv_x = 13'd100; x_neg = 1'b0; cv_y = 13'd50; y_neg = 1'b1; t_width = 11'd525; t_height = 11'd525;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= int'(LATENCY) + 5 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
        end
        vectors++;
        if (lat != int'(LATENCY) || x !== 11'd362 || y !== 10'd212) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d x=%0d y=%0d expected %0d 362 212", lat, x, y, LATENCY);
        end
        cv_x = 13'd7; x_neg = 1'b1; cv_y = 13'd0; y_neg = 1'b0; t_width = 11'd100; t_height = 11'd525;
        start = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_cycle_start: got busy=%0b expected 0", busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_idle_accept: got busy=%0b expected 1", busy);
        end
        lat = 0;
        for (int i = 1; i <= int'(LATENCY) + 5 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
        end
        vectors++;
        if (lat != int'(LATENCY) || x !== 11'd261 || y !== 10'd262 || clip !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d x=%0d y=%0d clip=%0b expected %0d 261 262 0",
                     lat, x, y, clip, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        run_vector("center",    13'd0,    1'b0, 13'd0,    1'b0, 11'd525,  11'd525,  11'd262, 10'd262, 1'b0, 1'b0);
        run_vector("signs",     13'd100,  1'b0, 13'd50,   1'b1, 11'd525,  11'd525,  11'd362, 10'd212, 1'b0, 1'b0);
        run_vector("scale",     13'd100,  1'b0, 13'd1,    1'b0, 11'd1050, 11'd400,  11'd462, Y_SMALL, 1'b0, 1'b0);
        run_vector("tw_zero",   13'd8191, 1'b1, 13'd0,    1'b1, 11'd0,    11'd2047, 11'd262, 10'd262, 1'b0, 1'b0);
        run_vector("clamp_xhi", 13'd300,  1'b0, 13'd0,    1'b0, 11'd525,  11'd525,  11'd524, 10'd262, 1'b1, 1'b0);
        run_vector("clamp_xlo", 13'd300,  1'b1, 13'd0,    1'b0, 11'd525,  11'd525,  11'd0,   10'd262, 1'b1, 1'b0);
        run_vector("clamp_yhi", 13'd0,    1'b0, 13'd8191, 1'b0, 11'd525,  11'd2047, 11'd262, 10'd524, 1'b1, 1'b0);
        run_vector("retrigger", 13'd7,    1'b1, 13'd50,   1'b0, 11'd100,  11'd525,  11'd261, 10'd312, 1'b0, 1'b1);
        test_abort();
        run_vector("recover",   13'd100,  1'b1, 13'd50,   1'b1, 11'd525,  11'd525,  11'd162, 10'd212, 1'b0, 1'b0);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
